// File: rtl/ctrl_queue_pkg.sv
// Shared definitions for the queued control unit: opcode encoding, instruction
// field positions and the legality check used by the dispatcher.
package ctrl_pkg;

    localparam int INST_W = 32;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 29;
    localparam int EU_MSB = 28;
    localparam int EU_LSB = 24;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_MOVE  = 3'd2,
        OP_FETCH = 3'd3,
        OP_EXEC  = 3'd4,
        OP_SYNC  = 3'd5,
        OP_ILL6  = 3'd6,
        OP_ILL7  = 3'd7
    } opcode_t;

    // FETCH/EXEC are only legal when the EU index names an existing unit.
    function automatic logic is_legal(input logic [INST_W-1:0] inst, input int n_eu);
        opcode_t op;
        int      idx;
        logic    unused_low;
        op         = opcode_t'(inst[OP_MSB:OP_LSB]);
        idx        = {27'd0, inst[EU_MSB:EU_LSB]};
        unused_low = ^inst[EU_LSB-1:0];
        case (op)
            OP_LOAD, OP_STORE, OP_MOVE, OP_SYNC: return 1'b1;
            OP_FETCH, OP_EXEC:                   return idx < n_eu;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_queue_if.sv
// Host-side instruction push port of the control queue.
// Push semantics: h2f_write is a valid with no ready; the word is taken on the
// edge where it is high, or dropped (and flagged) if the queue has no room.
interface ctrl_queue_if;
    import ctrl_pkg::*;

    logic [INST_W-1:0] h2f_io;
    logic              h2f_write;

    modport master (output h2f_io, output h2f_write);
    modport slave  (input  h2f_io, input  h2f_write);

endinterface

// File: rtl/ctrl_queue_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module inst_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers rely on DEPTH being a power of two so they wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ctrl_queue.sv
// Queued control unit: buffers host instructions and dispatches them in order
// to the load-storer, mover and execution units as their busy flags allow.
module ctrl_queue
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int N_EU  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    ctrl_queue_if.slave                host,
    input  logic                       err_clr,
    input  logic                       ldst_done,
    input  logic                       move_done,
    input  logic [N_EU-1:0]            eu_done,
    output logic                       isrunning,
    output logic                       q_full,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       ovf_err,
    output logic                       inst_err,
    output logic                       load_start,
    output logic                       store_start,
    output logic                       move_start,
    output logic [N_EU-1:0]            eu_fetch,
    output logic [N_EU-1:0]            eu_exec,
    output logic [INST_W-1:0]          inst_out,
    output logic                       rf_ram_sel,
    output logic                       sync_done
);

    logic [INST_W-1:0] head;
    logic              fifo_empty;
    logic              pop;
    opcode_t           head_op;
    logic [4:0]        head_idx;
    logic              head_legal;
    logic [N_EU-1:0]   eu_onehot;
    logic              eu_free, any_busy, any_pulse, issue_ok;

    logic              load_start_q, load_start_d;
    logic              store_start_q, store_start_d;
    logic              move_start_q, move_start_d;
    logic [N_EU-1:0]   eu_fetch_q, eu_fetch_d;
    logic [N_EU-1:0]   eu_exec_q, eu_exec_d;
    logic              sync_done_q, sync_done_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d;
    logic              rf_ram_sel_q, rf_ram_sel_d;
    logic              ldst_busy_q, ldst_busy_d;
    logic              move_busy_q, move_busy_d;
    logic [N_EU-1:0]   eu_busy_q, eu_busy_d;
    logic              ovf_err_q, ovf_err_d;
    logic              inst_err_q, inst_err_d;

    inst_fifo #(.W(INST_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (host.h2f_write),
        .din_i   (host.h2f_io),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (q_full),
        .empty_o (fifo_empty),
        .count_o (q_count)
    );

    assign head_op    = opcode_t'(head[OP_MSB:OP_LSB]);
    assign head_idx   = head[EU_MSB:EU_LSB];
    assign head_legal = is_legal(head, N_EU);

    always_comb begin
        eu_onehot = '0;
        for (int i = 0; i < N_EU; i++) eu_onehot[i] = (head_idx == 5'(i));
    end

    assign eu_free   = ~|(eu_onehot & eu_busy_q);
    assign any_busy  = ldst_busy_q | move_busy_q | (|eu_busy_q);
    assign any_pulse = load_start_q | store_start_q | move_start_q
                     | (|eu_fetch_q) | (|eu_exec_q);

    // LOAD/STORE/MOVE all contend for the RF RAM, so any of them blocks the others.
    always_comb begin
        issue_ok = 1'b0;
        if (!head_legal) begin
            issue_ok = 1'b1;
        end else begin
            case (head_op)
                OP_LOAD, OP_STORE, OP_MOVE: issue_ok = !ldst_busy_q && !move_busy_q;
                OP_FETCH, OP_EXEC:          issue_ok = eu_free;
                OP_SYNC:                    issue_ok = !any_busy && !any_pulse;
                default:                    issue_ok = 1'b1;
            endcase
        end
        pop = !fifo_empty && issue_ok;
    end

    always_comb begin
        load_start_d  = 1'b0;
        store_start_d = 1'b0;
        move_start_d  = 1'b0;
        eu_fetch_d    = '0;
        eu_exec_d     = '0;
        sync_done_d   = 1'b0;
        inst_out_d    = inst_out_q;
        rf_ram_sel_d  = rf_ram_sel_q;
        if (pop && head_legal) begin
            case (head_op)
                OP_LOAD:  begin load_start_d  = 1'b1; rf_ram_sel_d = 1'b1; end
                OP_STORE: begin store_start_d = 1'b1; rf_ram_sel_d = 1'b1; end
                OP_MOVE:  begin move_start_d  = 1'b1; rf_ram_sel_d = 1'b0; end
                OP_FETCH: eu_fetch_d  = eu_onehot;
                OP_EXEC:  eu_exec_d   = eu_onehot;
                OP_SYNC:  sync_done_d = 1'b1;
                default:  ;
            endcase
            // SYNC is a barrier only; inst_out keeps the last word a unit decodes.
            if (head_op != OP_SYNC) inst_out_d = head;
        end
        ldst_busy_d = (ldst_busy_q && !ldst_done) || load_start_d || store_start_d;
        move_busy_d = (move_busy_q && !move_done) || move_start_d;
        eu_busy_d   = (eu_busy_q & ~eu_done) | eu_fetch_d | eu_exec_d;
        ovf_err_d   = (ovf_err_q && !err_clr) || (host.h2f_write && q_full && !pop);
        inst_err_d  = (inst_err_q && !err_clr) || (pop && !head_legal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_start_q  <= 1'b0;
            store_start_q <= 1'b0;
            move_start_q  <= 1'b0;
            eu_fetch_q    <= '0;
            eu_exec_q     <= '0;
            sync_done_q   <= 1'b0;
            inst_out_q    <= '0;
            rf_ram_sel_q  <= 1'b0;
            ldst_busy_q   <= 1'b0;
            move_busy_q   <= 1'b0;
            eu_busy_q     <= '0;
            ovf_err_q     <= 1'b0;
            inst_err_q    <= 1'b0;
        end else begin
            load_start_q  <= load_start_d;
            store_start_q <= store_start_d;
            move_start_q  <= move_start_d;
            eu_fetch_q    <= eu_fetch_d;
            eu_exec_q     <= eu_exec_d;
            sync_done_q   <= sync_done_d;
            inst_out_q    <= inst_out_d;
            rf_ram_sel_q  <= rf_ram_sel_d;
            ldst_busy_q   <= ldst_busy_d;
            move_busy_q   <= move_busy_d;
            eu_busy_q     <= eu_busy_d;
            ovf_err_q     <= ovf_err_d;
            inst_err_q    <= inst_err_d;
        end
    end

    assign load_start  = load_start_q;
    assign store_start = store_start_q;
    assign move_start  = move_start_q;
    assign eu_fetch    = eu_fetch_q;
    assign eu_exec     = eu_exec_q;
    assign sync_done   = sync_done_q;
    assign inst_out    = inst_out_q;
    assign rf_ram_sel  = rf_ram_sel_q;
    assign ovf_err     = ovf_err_q;
    assign inst_err    = inst_err_q;
    assign isrunning   = (q_count != '0) || any_busy || any_pulse;

endmodule

// File: tb/tb_ctrl_queue.sv
// Directed bench for ctrl_queue: a queue-level reference model checked every
// cycle, plus hand-computed spot checks along the scenario.
module tb_ctrl_queue;

  localparam int DEPTH = 8;
  localparam int N_EU  = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            err_clr = 1'b0;
  logic            ldst_done = 1'b0;
  logic            move_done = 1'b0;
  logic [N_EU-1:0] eu_done = '0;
  logic            isrunning, q_full, ovf_err, inst_err;
  logic [CW-1:0]   q_count;
  logic            load_start, store_start, move_start, sync_done, rf_ram_sel;
  logic [N_EU-1:0] eu_fetch, eu_exec;
  logic [31:0]     inst_out;

  ctrl_queue_if host_if ();

  ctrl_queue #(.DEPTH(DEPTH), .N_EU(N_EU)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host_if),
    .err_clr     (err_clr),
    .ldst_done   (ldst_done),
    .move_done   (move_done),
    .eu_done     (eu_done),
    .isrunning   (isrunning),
    .q_full      (q_full),
    .q_count     (q_count),
    .ovf_err     (ovf_err),
    .inst_err    (inst_err),
    .load_start  (load_start),
    .store_start (store_start),
    .move_start  (move_start),
    .eu_fetch    (eu_fetch),
    .eu_exec     (eu_exec),
    .inst_out    (inst_out),
    .rf_ram_sel  (rf_ram_sel),
    .sync_done   (sync_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: instruction queue plus unit occupancy
  logic [31:0]     exp_q[$];
  bit              m_ldst, m_mvb;
  bit [N_EU-1:0]   m_eub;
  bit              m_load, m_store, m_mv, m_sync, m_sel, m_ovf, m_ierr;
  bit [N_EU-1:0]   m_fetch, m_exec;
  logic [31:0]     m_inst;
  logic [31:0]     m_h;
  bit              m_iss, m_anyp;
  int              m_op, m_idx;

  function automatic bit tb_legal(input logic [31:0] w);
    int op  = int'(w[31:29]);
    int idx = int'(w[28:24]);
    if (op > 5) return 1'b0;
    if ((op == 3 || op == 4) && idx >= N_EU) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ldst = 0; m_mvb = 0; m_eub = '0;
      m_load = 0; m_store = 0; m_mv = 0; m_sync = 0; m_fetch = '0; m_exec = '0;
      m_sel = 0; m_ovf = 0; m_ierr = 0; m_inst = '0;
    end else begin
      m_anyp = m_load || m_store || m_mv || (m_fetch != 0) || (m_exec != 0);
      m_iss = 0;
      if (exp_q.size() > 0) begin
        m_h   = exp_q[0];
        m_op  = int'(m_h[31:29]);
        m_idx = int'(m_h[28:24]);
        if (!tb_legal(m_h)) m_iss = 1;
        else if (m_op <= 2) m_iss = !m_ldst && !m_mvb;
        else if (m_op <= 4) m_iss = !m_eub[m_idx];
        else m_iss = !m_ldst && !m_mvb && (m_eub == 0) && !m_anyp;
      end
      m_load = 0; m_store = 0; m_mv = 0; m_sync = 0; m_fetch = '0; m_exec = '0;
      if (ldst_done) m_ldst = 0;
      if (move_done) m_mvb = 0;
      m_eub = m_eub & ~eu_done;
      if (err_clr) begin m_ovf = 0; m_ierr = 0; end
      if (m_iss) begin
        void'(exp_q.pop_front());
        if (!tb_legal(m_h)) m_ierr = 1;
        else begin
          case (m_op)
            0: begin m_load = 1;  m_ldst = 1; m_sel = 1; end
            1: begin m_store = 1; m_ldst = 1; m_sel = 1; end
            2: begin m_mv = 1;    m_mvb = 1;  m_sel = 0; end
            3: begin m_fetch = N_EU'(1) << m_idx; m_eub[m_idx] = 1; end
            4: begin m_exec  = N_EU'(1) << m_idx; m_eub[m_idx] = 1; end
            default: m_sync = 1;
          endcase
          if (m_op != 5) m_inst = m_h;
        end
      end
      if (host_if.h2f_write) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(host_if.h2f_io);
        else m_ovf = 1;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      check("load_start", load_start, m_load);
      check("store_start", store_start, m_store);
      check("move_start", move_start, m_mv);
      check("eu_fetch", eu_fetch, m_fetch);
      check("eu_exec", eu_exec, m_exec);
      check("sync_done", sync_done, m_sync);
      check("inst_out", inst_out, m_inst);
      check("rf_ram_sel", rf_ram_sel, m_sel);
      check("q_count", q_count, exp_q.size());
      check("q_full", q_full, exp_q.size() == DEPTH);
      check("ovf_err", ovf_err, m_ovf);
      check("inst_err", inst_err, m_ierr);
      check("isrunning", isrunning,
            (exp_q.size() != 0) || m_ldst || m_mvb || (m_eub != 0) ||
            m_load || m_store || m_mv || (m_fetch != 0) || (m_exec != 0));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    host_if.h2f_io    = w;
    host_if.h2f_write = 1'b1;
    tick();
    host_if.h2f_write = 1'b0;
  endtask

  localparam logic [31:0] I_LOAD  = 32'h0000_1234;
  localparam logic [31:0] I_STORE = 32'h2000_0055;
  localparam logic [31:0] I_MOVE  = 32'h4000_0077;
  localparam logic [31:0] I_SYNC  = 32'hA000_0000;
  localparam logic [31:0] I_F0    = 32'h6000_0001;
  localparam logic [31:0] I_E2    = 32'h8200_0002;
  localparam logic [31:0] I_E5    = 32'h8500_0005;
  localparam logic [31:0] I_X     = 32'h8700_BEEF;

  initial begin
    host_if.h2f_io    = '0;
    host_if.h2f_write = 1'b0;
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset isrunning", isrunning, 0);
    check("reset q_count", q_count, 0);
    check("reset inst_out", inst_out, 0);

    // single LOAD: start pulse two cycles after the push
    push(I_LOAD);
    check("load early", load_start, 0);
    tick();
    check("load pulse", load_start, 1);
    check("load sel", rf_ram_sel, 1);
    tick();
    check("load busy running", isrunning, 1);
    ldst_done = 1'b1; tick(); ldst_done = 1'b0;
    check("idle after done", isrunning, 0);

    // LOAD then MOVE: MOVE waits for ldst_done
    push(I_LOAD);
    push(I_MOVE);
    check("load2 pulse", load_start, 1);
    repeat (3) tick();
    ldst_done = 1'b1; tick(); ldst_done = 1'b0;
    check("move withheld", move_start, 0);
    tick();
    check("move pulse", move_start, 1);
    check("move sel", rf_ram_sel, 0);
    move_done = 1'b1; tick(); move_done = 1'b0;
    push(I_STORE);
    tick();
    check("store pulse", store_start, 1);
    ldst_done = 1'b1; tick(); ldst_done = 1'b0;

    // EXEC eu2, eu5, eu2
    push(I_E2);
    push(I_E5);
    check("exec eu2", eu_exec, 8'h04);
    push(I_E2);
    check("exec eu5", eu_exec, 8'h20);
    tick();
    check("exec eu2 blocked", eu_exec, 0);
    eu_done = 8'h04; tick(); eu_done = '0;
    check("exec eu2 wait", eu_exec, 0);
    tick();
    check("exec eu2 again", eu_exec, 8'h04);
    eu_done = 8'h24; tick(); eu_done = '0;

    // overflow with a blocked head, then push during pop
    push(I_LOAD);
    push(I_MOVE);
    for (int i = 0; i < 7; i++) push(32'h8000_A000 | (i << 24) | i);
    push(32'h8700_0099);
    check("ovf q_full", q_full, 1);
    check("ovf q_count", q_count, 8);
    check("ovf flag", ovf_err, 1);
    ldst_done = 1'b1; tick(); ldst_done = 1'b0;
    push(I_X);
    check("push+pop count", q_count, 8);
    check("push+pop move", move_start, 1);
    repeat (8) tick();
    check("wrap last exec", eu_exec, 8'h80);
    check("wrap last inst", inst_out, I_X);
    eu_done = 8'hFF; move_done = 1'b1; tick(); eu_done = '0; move_done = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovf cleared", ovf_err, 0);

    // illegal opcode and out-of-range EU
    push(32'hE000_0000);
    push(32'h9F00_0000);
    check("inst_err set", inst_err, 1);
    tick();
    check("illegal drained", q_count, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("inst_err cleared", inst_err, 0);
    push(32'hC000_0000);
    err_clr = 1'b1; tick();
    check("set beats clear", inst_err, 1);
    tick(); err_clr = 1'b0;
    check("clear after set", inst_err, 0);

    // MOVE, SYNC, FETCH eu0, then reset while busy
    push(I_MOVE);
    push(I_SYNC);
    push(I_F0);
    tick();
    move_done = 1'b1; tick(); move_done = 1'b0;
    check("sync early", sync_done, 0);
    tick();
    check("sync pulse", sync_done, 1);
    check("fetch after sync wait", eu_fetch, 0);
    tick();
    check("fetch eu0", eu_fetch, 8'h01);
    push(I_F0);
    push(I_LOAD);
    rst = 1'b1; tick();
    check("rst isrunning", isrunning, 0);
    check("rst q_count", q_count, 0);
    check("rst inst_out", inst_out, 0);
    check("rst sel", rf_ram_sel, 0);
    rst = 1'b0; tick();
    eu_done = 8'h01; tick(); eu_done = '0;
    tick();
    check("idle after rst", isrunning, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_queue.md
# ctrl_queue

Queued successor to the single-shot control unit. Accepts 32-bit instructions from the AvMM IO path into a parametrised FIFO, then dispatches them in order to the load-storer, mover and `N_EU` execution units. Tracks each unit's busy state through done pulses, so the host no longer has to wait for one instruction to finish before writing the next. Owns `rf_ram_sel`; adds a SYNC barrier and sticky error reporting.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2
- `N_EU`, 8: number of execution units, 1..32
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `h2f_io`  in  32  instruction word
- `h2f_write`  in  1  push `h2f_io` this cycle
- `err_clr`  in  1  clears sticky error flags
- `ldst_done`, `move_done`  in  1 each  one-cycle completion pulse from the unit
- `eu_done`  in  N_EU  per-EU completion pulse
- `isrunning`  out  1  queue non-empty or any unit busy
- `q_full`  out  1  FIFO count == DEPTH
- `q_count`  out  $clog2(DEPTH+1)  FIFO occupancy
- `ovf_err`, `inst_err`  out  1 each  sticky: push dropped / illegal instruction discarded
- `load_start`, `store_start`, `move_start`  out  1 each  one-cycle start pulse
- `eu_fetch`, `eu_exec`  out  N_EU  one-hot start pulse
- `inst_out`  out  32  last issued instruction; field decode happens in the units
- `rf_ram_sel`  out  1  1: load-storer owns RF RAM; 0: mover owns it
- `sync_done`  out  1  one-cycle pulse when a SYNC retires

## Operation
- Opcode `[31:29]`: 0 LOAD, 1 STORE, 2 MOVE, 3 FETCH, 4 EXEC, 5 SYNC, 6–7 illegal. EU index is `[28:24]`; an index ≥ N_EU is illegal.
- Busy flags `ldst_busy`, `move_busy`, `eu_busy[N_EU]`:
  - set on the matching start pulse; cleared on the matching done pulse.
  - A done with the flag already clear is ignored.
  - FETCH and EXEC to the same EU share one flag.
- Issue condition, evaluated on the FIFO head each cycle:
  - LOAD/STORE/MOVE: `ldst_busy==0 && move_busy==0`, because both share the RF RAM.
  - FETCH/EXEC: `eu_busy[idx]==0`.
  - SYNC: all flags clear and no start pulse currently asserted.
  - Illegal: always issues; discarded and sets `inst_err`.
- In-order issue, at most one instruction per cycle. A blocked head stalls the whole queue.
- On issue:
  - head popped; start pulse registered.
  - `inst_out` loaded.
  - `rf_ram_sel` set to 1 (LOAD/STORE) or 0 (MOVE) in the same edge.
  - FETCH/EXEC decode the index to one-hot.
  - SYNC produces only `sync_done`.
- Push while full is dropped and sets `ovf_err`, unless a pop happens in the same cycle; in that case it is accepted and the count is unchanged.
- Push and pop together when not full: count unchanged; read and write pointers wrap modulo DEPTH.
- Errors clear on `err_clr` or `rst`. A set and `err_clr` in the same cycle leaves the flag set.
- `isrunning` = `q_count!=0` OR any busy flag OR any start pulse high.

## Timing
- Reset values: FIFO empty, all flags 0, all pulses 0, `inst_out`=0, `rf_ram_sel`=0, `isrunning`=0, errors 0.
- `rst` mid-operation abandons all queued and in-flight instructions. Units are reset separately.
- Push sampled at edge T; head valid in T+1.
- If issuable, the start pulse and new `inst_out` are high/valid in T+2 only. Minimum push-to-start latency is 2 cycles.
- The busy flag is set at the same edge as the start pulse. The next instruction to the same unit can therefore never issue in T+3.
- Done at edge D clears the flag. A dependent head issues with its pulse in D+1.
- Back-to-back issue to different EUs: one pulse per cycle.

## Structure
- Package `ctrl_pkg`:
  - `opcode_t` enum.
  - field-position localparams (`OP_MSB`, `OP_LSB`, `EU_MSB`, `EU_LSB`).
  - function `is_legal(inst, n_eu)`.
- Sub-module `inst_fifo #(W, DEPTH)`: synchronous FIFO with count, full/empty, same-cycle push/pop. The dispatcher stays in `ctrl_queue`.

## Test plan
- Reset, then push LOAD → `load_start` pulses 2 cycles after the push, `rf_ram_sel`=1, `isrunning`=1 until `ldst_done`.
- Push LOAD then MOVE → `move_start` withheld until 1 cycle after `ldst_done`; `rf_ram_sel` goes 1 then 0.
- Push EXEC eu=2, EXEC eu=5, EXEC eu=2 → `eu_exec`=0x04 then 0x20 on consecutive cycles; the third pulse comes 1 cycle after `eu_done[2]`.
- DEPTH=8 with head blocked: 9 pushes → `q_full`=1, `ovf_err`=1, `q_count`=8. Then a push coinciding with a pop is accepted, `q_count` stays 8, and the wrapped data order is preserved.
- Opcode 7, then EXEC eu=31 with N_EU=8 → both discarded with no start pulse; `inst_err`=1 until `err_clr`.
- MOVE, SYNC, FETCH eu=0 → `sync_done` pulses 1 cycle after `move_done`; `eu_fetch`=0x01 in the following cycle. Assert `rst` while busy → all outputs return to reset values next cycle.
